// File: rtl/neopixel_sequencer_if.sv
// neopixel_sequencer_if: bundle between display logic, sequencer and strip driver.
// Signals: start, top_codes, bottom_codes, ready (into the sequencer);
//          load, go, pixel, red, green, blue, busy, done_displaying (out of it).
// master = sequencer side, slave = environment (display logic + driver).
interface neopixel_sequencer_if;
   logic        start;
   logic [11:0] top_codes;
   logic [11:0] bottom_codes;
   logic        ready;
   logic        load;
   logic        go;
   logic [2:0]  pixel;
   logic [7:0]  red;
   logic [7:0]  green;
   logic [7:0]  blue;
   logic        busy;
   logic        done_displaying;

   modport master (
      input  start, top_codes, bottom_codes, ready,
      output load, go, pixel, red, green, blue, busy, done_displaying
   );

   modport slave (
      output start, top_codes, bottom_codes, ready,
      input  load, go, pixel, red, green, blue, busy, done_displaying
   );
endinterface

// File: rtl/neopixel_sequencer.sv
// neopixel_sequencer: snapshots two 12-bit code rows, streams 8 pixels into
// the strip driver with load, fires go, waits for the transfer, pulses done.
// Ports: clock, reset (sync, active-high), bus (neopixel_sequencer_if.master).
// Parameter BRIGHT: channel value of an "on" colour component.
// Optional macro NEOPIXEL_SEQ_SKIP_SAME_EN: skip the strip update when the
// requested codes equal the last displayed ones.
module neopixel_sequencer #(
   parameter logic [7:0] BRIGHT = 8'd32
) (
   input  logic                        clock,
   input  logic                        reset,
   neopixel_sequencer_if.master        bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_GO,
      S_SETTLE,
      S_WAIT_RDY,
      S_DONE
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [2:0]  r_idx;
   logic [2:0]  w_idx_nxt;
   logic [23:0] r_snap;
   logic [23:0] w_snap_nxt;
   logic [4:0]  w_shift;
   logic [2:0]  w_code;
   logic        w_load;
   logic        w_go;
   logic        w_done;
   logic        w_busy;
   logic        w_same;
   logic [7:0]  w_red;
   logic [7:0]  w_green;
   logic [7:0]  w_blue;

`ifdef NEOPIXEL_SEQ_SKIP_SAME_EN
   logic [23:0] r_last;
   logic        r_last_vld;

   // Remember what actually reached the strip.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_last     <= '0;
         r_last_vld <= 1'b0;
      end else if (r_state == S_DONE) begin
         r_last     <= r_snap;
         r_last_vld <= 1'b1;
      end
   end

   assign w_same = r_last_vld &&
                   ({bus.bottom_codes, bus.top_codes} == r_last);
`else
   assign w_same = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
         r_snap  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_snap  <= w_snap_nxt;
      end
   end

   // Pixel p of the snapshot lives at bits [3p+2:3p].
   assign w_shift = {2'b00, r_idx} * 5'd3;
   assign w_code  = r_snap[w_shift +: 3];

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_snap_nxt  = r_snap;
      w_load      = 1'b0;
      w_go        = 1'b0;
      w_done      = 1'b0;
      w_busy      = (r_state != S_IDLE);
      unique case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_snap_nxt  = {bus.bottom_codes, bus.top_codes};
               w_idx_nxt   = '0;
               w_state_nxt = w_same ? S_DONE : S_LOAD;
            end
         end
         S_LOAD: begin
            if (bus.ready) begin
               w_load    = 1'b1;
               w_idx_nxt = r_idx + 3'd1;
               if (r_idx == 3'd7) begin
                  w_state_nxt = S_GO;
               end
            end
         end
         S_GO: begin
            if (bus.ready) begin
               w_go        = 1'b1;
               w_state_nxt = S_SETTLE;
            end
         end
         // Driver drops ready one cycle after go; do not trust it yet.
         S_SETTLE: begin
            w_state_nxt = S_WAIT_RDY;
         end
         S_WAIT_RDY: begin
            if (bus.ready) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Colour bus is forced to zero whenever no load is issued.
   always_comb begin
      w_red   = '0;
      w_green = '0;
      w_blue  = '0;
      if (w_load) begin
         unique case (w_code)
            3'd0: begin
               w_red   = BRIGHT;
               w_green = BRIGHT;
               w_blue  = BRIGHT;
            end
            3'd1: w_green = BRIGHT;
            3'd2: begin
               w_red   = BRIGHT;
               w_green = BRIGHT;
            end
            3'd3: w_red  = BRIGHT;
            3'd4: w_blue = BRIGHT;
            default: begin
               w_red   = '0;
               w_green = '0;
               w_blue  = '0;
            end
         endcase
      end
   end

   assign bus.load            = w_load;
   assign bus.go              = w_go;
   assign bus.pixel           = w_load ? r_idx : 3'd0;
   assign bus.red             = w_red;
   assign bus.green           = w_green;
   assign bus.blue            = w_blue;
   assign bus.busy            = w_busy;
   assign bus.done_displaying = w_done;

endmodule

// File: tb/tb_neopixel_sequencer.sv
// tb_neopixel_sequencer: directed stimulus, expected load/go/done events
// queued by the driver and popped by a negedge monitor.
module tb_neopixel_sequencer;

   localparam logic [7:0] BR = 8'd32;
`ifdef NEOPIXEL_SEQ_SKIP_SAME_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   neopixel_sequencer_if bus ();

   neopixel_sequencer #(.BRIGHT(BR)) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [1:0]  kind;
      logic [31:0] at;
      logic [2:0]  pix;
      logic [23:0] rgb;
   } ev_t;

   ev_t q[$];
   int  n_chk  = 0;
   int  n_pass = 0;

   task automatic check(input string nm, input logic [63:0] act,
                        input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h required %h (cycle %0d)",
                    nm, act, exp, cyc);
   endtask

   function automatic logic [23:0] rgb(input logic [2:0] c);
      case (c)
         3'd0:    return {BR, BR, BR};
         3'd1:    return {8'd0, BR, 8'd0};
         3'd2:    return {BR, BR, 8'd0};
         3'd3:    return {BR, 8'd0, 8'd0};
         3'd4:    return {8'd0, 8'd0, BR};
         default: return 24'd0;
      endcase
   endfunction

   task automatic wait_cyc(input int target);
      while (cyc < target) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor
   always @(negedge clk) begin
      ev_t a;
      ev_t e;
      if (bus.load || bus.go || bus.done_displaying) begin
         a.kind = bus.load ? 2'd0 : (bus.go ? 2'd1 : 2'd2);
         a.at   = cyc;
         a.pix  = bus.pixel;
         a.rgb  = {bus.red, bus.green, bus.blue};
         if (q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_event: got kind %0d pixel %0d at cycle %0d, required none",
                     a.kind, a.pix, cyc);
         end else begin
            e = q.pop_front();
            check("event", 64'(a), 64'(e));
         end
      end
      if (bus.load === 1'b0)
         check("unloaded_zero",
               64'({bus.pixel, bus.red, bus.green, bus.blue}), 64'd0);
   end

   task automatic run(input logic [11:0] t, input logic [11:0] b,
                      input int stall_at, input int stall_n,
                      input int rdy_low, input int hold_lo,
                      input int hold_hi, input bit skip);
      int t0;
      int go_c;
      int done_c;
      logic [2:0] c;
      ev_t e;
      t0 = cyc;
      go_c = 0;
      bus.top_codes    = t;
      bus.bottom_codes = b;
      bus.start        = 1'b1;
      bus.ready        = 1'b1;
      if (skip) begin
         done_c = t0 + 1;
      end else begin
         for (int p = 0; p < 8; p++) begin
            c = (p < 4) ? t[3*p +: 3] : b[3*(p-4) +: 3];
            e.kind = 2'd0;
            e.at   = t0 + 1 + p + ((p >= stall_at) ? stall_n : 0);
            e.pix  = 3'(p);
            e.rgb  = rgb(c);
            q.push_back(e);
         end
         go_c   = t0 + 9 + stall_n;
         e.kind = 2'd1;
         e.at   = go_c;
         e.pix  = 3'd0;
         e.rgb  = 24'd0;
         q.push_back(e);
         done_c = go_c + rdy_low + 2;
      end
      e.kind = 2'd2;
      e.at   = done_c;
      e.pix  = 3'd0;
      e.rgb  = 24'd0;
      q.push_back(e);
      for (int k = 1; k <= done_c - t0 + 1; k++) begin
         wait_cyc(t0 + k);
         bus.start        = (k >= hold_lo) && (k <= hold_hi);
         bus.top_codes    = ~t;
         bus.bottom_codes = ~b;
         bus.ready = !((!skip && k >= 1 + stall_at &&
                        k < 1 + stall_at + stall_n) ||
                       (!skip && t0 + k > go_c &&
                        t0 + k <= go_c + rdy_low));
         check("busy", 64'(bus.busy), 64'(t0 + k <= done_c));
      end
   endtask

   localparam logic [11:0] TA = 12'o3210;
   localparam logic [11:0] BA = 12'o7654;
   localparam logic [11:0] TB = 12'o4321;
   localparam logic [11:0] BB = 12'o0123;
   localparam logic [11:0] TC = 12'o0000;
   localparam logic [11:0] BC = 12'o1111;

   initial begin
      int t0;
      ev_t e;
      bus.start        = 1'b0;
      bus.ready        = 1'b1;
      bus.top_codes    = '0;
      bus.bottom_codes = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs",
            64'({bus.load, bus.go, bus.busy, bus.done_displaying,
                 bus.pixel, bus.red, bus.green, bus.blue}), 64'd0);
      rst = 1'b0;
      wait_cyc(cyc + 2);

      // Basic update, driver busy cycles 10-20.
      run(TA, BA, 8, 0, 11, 0, -1, 1'b0);
      wait_cyc(cyc + 2);
      // Stall of 4 cycles at pixel 3.
      run(TB, BB, 3, 4, 3, 0, -1, 1'b0);
      wait_cyc(cyc + 2);
      // start re-asserted cycles 2-15 is ignored.
      run(TA, BA, 8, 0, 7, 2, 15, 1'b0);
      wait_cyc(cyc + 2);

      // Reset in cycle 5 of LOAD aborts the update.
      t0 = cyc;
      bus.top_codes    = TA;
      bus.bottom_codes = BA;
      bus.start        = 1'b1;
      for (int p = 0; p < 5; p++) begin
         e.kind = 2'd0;
         e.at   = t0 + 1 + p;
         e.pix  = 3'(p);
         e.rgb  = rgb((p < 4) ? TA[3*p +: 3] : BA[2:0]);
         q.push_back(e);
      end
      wait_cyc(t0 + 1);
      bus.start = 1'b0;
      wait_cyc(t0 + 5);
      rst = 1'b1;
      wait_cyc(t0 + 6);
      rst = 1'b0;
      check("abort_outputs",
            64'({bus.load, bus.go, bus.busy, bus.done_displaying,
                 bus.pixel, bus.red, bus.green, bus.blue}), 64'd0);
      wait_cyc(cyc + 20);

      // Repeat with identical codes, then changed codes.
      run(TA, BA, 8, 0, 2, 0, -1, 1'b0);
      wait_cyc(cyc + 2);
      run(TA, BA, 8, 0, 2, 0, -1, SKIP);
      wait_cyc(cyc + 2);
      run(TC, BC, 8, 0, 2, 0, -1, 1'b0);

      wait_cyc(cyc + 4);
      check("queue_drained", 64'(q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish, required finish");
      $fatal(1);
   end

endmodule
